if_id_fetch_buffer: RTL and testbench

- Small instruction queue between the IF stage and the decode (ID) stage of the RV32I pipeline.
- Captures fetched {pc, inst, pred_taken, pred_addr} tuples from IF and presents them in order to ID.
- Decouples IF from ID stalls with a valid/ready handshake on each side.
- Discards all queued instructions when a branch redirect (mispredict or flush) is signalled.

---
 rtl/if_id_fetch_buffer_pkg.sv | 12 +
 rtl/if_id_fetch_buffer_ctrl.sv | 68 ++++++
 rtl/if_id_fetch_buffer.sv | 72 +++++++
 tb/tb_if_id_fetch_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared constants for the IF/ID fetch buffer.
// Each entry is packed as {pc, inst, pred_taken, pred_addr}, MSB to LSB.
package if_id_fetch_buffer_pkg;
    localparam int XLEN = 32;
    localparam int ENTRY_W = 3 * XLEN + 1;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    localparam int PRED_ADDR_LSB = 0;
    localparam int PRED_TAKEN_BIT = XLEN;
    localparam int INST_LSB = XLEN + 1;
    localparam int PC_LSB = 2 * XLEN + 1;
endpackage

// File: rtl/if_id_fetch_buffer_ctrl.sv
// Pointer/occupancy control for the fetch buffer.
// A flush outranks any push or pop that happens in the same cycle.
module if_id_fetch_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush;
    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointer difference aliases to zero when full, so full is excluded.
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL_CNT);
    a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q == FULL_CNT) || (count_q == {1'b0, PTR_W'(wr_ptr_q - rd_ptr_q)}));
endmodule

// File: rtl/if_id_fetch_buffer.sv
// Instruction queue between IF and ID: register-array storage plus a head mux
// that substitutes a NOP on an empty queue.
module if_id_fetch_buffer
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_pred_taken,
    input  logic [31:0]      in_pred_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_pred_taken,
    output logic [31:0]      out_pred_addr,
    input  logic             flush,
    output logic [PTR_W:0]   count
);
    logic                   wr_en;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0]     mem_q [DEPTH];
    logic [ENTRY_W-1:0]     wr_entry;
    logic [ENTRY_W-1:0]     head;

    if_id_fetch_buffer_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .count     (count)
    );

    assign wr_entry = {in_pc, in_inst, in_pred_taken, in_pred_addr};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                mem_q[gi] <= '0;
            else if (wr_en && wr_ptr == PTR_W'(gi))
                mem_q[gi] <= wr_entry;
        end
    end

    assign head = mem_q[rd_ptr];

    always_comb begin
        out_pc         = '0;
        out_inst       = NOP_INST;
        out_pred_taken = 1'b0;
        out_pred_addr  = '0;
        if (out_valid) begin
            out_pc         = head[PC_LSB +: XLEN];
            out_inst       = head[INST_LSB +: XLEN];
            out_pred_taken = head[PRED_TAKEN_BIT];
            out_pred_addr  = head[PRED_ADDR_LSB +: XLEN];
        end
    end
endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed bench for the IF/ID fetch buffer; one line per checked transaction.
module tb_if_id_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst, in_pred_addr;
    logic        in_pred_taken;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst, out_pred_addr;
    logic        out_pred_taken;
    logic        flush;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    if_id_fetch_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_pred_taken  (in_pred_taken),
        .in_pred_addr   (in_pred_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pred_taken (out_pred_taken),
        .out_pred_addr  (out_pred_addr),
        .flush          (flush),
        .count          (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_inst [4];
    logic [31:0] q_pc [$];
    logic        q_pt [$];
    logic [31:0] q_pa [$];

    initial begin
        fill_inst[0] = 32'h00A0_0093;
        fill_inst[1] = 32'h0140_0113;
        fill_inst[2] = 32'h01E0_0193;
        fill_inst[3] = 32'h0280_0213;

        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_pred_taken = 1'b0; in_pred_addr = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'h0000_0013);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        $display("reset: out_valid=%0d out_inst=%h count=%0d", out_valid, out_inst, count);

        // Fill to full without consuming
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 32'(i * 4); in_inst = fill_inst[i];
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_head_pc", out_pc, 32'h0);
            $display("push pc=%h count=%0d", in_pc, count);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_pc = 32'h10; in_inst = 32'hDEAD_BEEF;
        step();
        check("full_ignore_count", 32'(count), 32'd4);
        check("full_ignore_head", out_pc, 32'h0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 32'(i * 4));
            check("drain_inst", out_inst, fill_inst[i]);
            $display("pop pc=%h inst=%h", out_pc, out_inst);
            step();
        end
        check("drain_empty_valid", 32'(out_valid), 32'd0);
        check("drain_empty_nop", out_inst, 32'h0000_0013);

        // Streaming: one in, one out per cycle
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h100 + 32'(k * 4); in_inst = 32'h0000_1000 + 32'(k);
            step();
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", out_pc, 32'h100 + 32'(k * 4));
            $display("stream in_pc=%h out_pc=%h count=%0d", in_pc, out_pc, count);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(count), 32'd0);

        // Flush colliding with a push and a pop
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h300 + 32'(i * 4);
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h200;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_nop", out_inst, 32'h0000_0013);
        step();
        check("flush_stays_empty", 32'(count), 32'd0);
        check("flush_pc_dropped", out_pc, 32'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        check("redirect_pc", out_pc, 32'h400);
        check("redirect_count", 32'(count), 32'd1);
        $display("flush: count=%0d redirect head pc=%h", count, out_pc);
        out_ready = 1'b1;
        step();
        check("redirect_popped", 32'(count), 32'd0);

        // Prediction fields across pointer wrap, pops interleaved
        begin
            int pushed = 0;
            int popped = 0;
            int cyc = 0;
            while (popped < 9 && cyc < 60) begin
                logic do_push, do_pop;
                in_valid = (pushed < 9);
                in_pc = 32'h500 + 32'(pushed * 4);
                in_inst = 32'h0000_2000 + 32'(pushed);
                in_pred_taken = pushed[0];
                in_pred_addr = pushed[0] ? in_pc + 32'h40 : 32'h0;
                out_ready = (cyc % 3 != 0);
                #1;
                check("wrap_count", 32'(count), 32'(q_pc.size()));
                check("wrap_in_ready", 32'(in_ready), 32'(q_pc.size() != 4));
                do_pop = out_ready && (q_pc.size() > 0);
                do_push = in_valid && (q_pc.size() < 4);
                if (do_pop) begin
                    check("wrap_pc", out_pc, q_pc[0]);
                    check("wrap_pred_taken", 32'(out_pred_taken), 32'(q_pt[0]));
                    check("wrap_pred_addr", out_pred_addr, q_pa[0]);
                    $display("wrap pop pc=%h taken=%0d addr=%h", out_pc, out_pred_taken, out_pred_addr);
                    void'(q_pc.pop_front()); void'(q_pt.pop_front()); void'(q_pa.pop_front());
                    popped++;
                end
                if (do_push) begin
                    q_pc.push_back(in_pc); q_pt.push_back(in_pred_taken); q_pa.push_back(in_pred_addr);
                    pushed++;
                end
                step();
                cyc++;
            end
            check("wrap_all_popped", 32'(popped), 32'd9);
        end
        in_valid = 1'b0; in_pred_taken = 1'b0; in_pred_addr = '0; out_ready = 1'b0;
        step();
        check("wrap_end_count", 32'(count), 32'd0);

        // Asynchronous reset between edges
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc = 32'h600 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        check("pre_areset_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_count", 32'(count), 32'd0);
        check("areset_nop", out_inst, 32'h0000_0013);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        $display("async reset: out_valid=%0d count=%0d", out_valid, count);
        step();
        rst_n = 1'b1;
        step();
        check("post_areset_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
